superbank_responder: RTL and testbench
======================================

SUPERBANK_RESPONDER -- requirements
Module: superbank_responder

Interface
REQ-001 SHALL have parameter TCDMAddrWidth, default 10, bank line address width.
REQ-002 SHALL have parameter BanksPerSuperbank (B), default 8, banks per superbank.
REQ-003 SHALL have parameter DMADataWidth, default 512, wide port data width; BankDataWidth (BW) = DMADataWidth/B.
REQ-004 SHALL have parameter AmoWidth, default 4, AMO opcode width.
REQ-005 SHALL have parameter MemoryLatency (L), default 1, bank read latency in cycles, L >= 1.
REQ-006 SHALL have ports: clk_i in 1 clock; rst_ni in 1 reset.
REQ-007 SHALL state as fixed: one clock; reset is asynchronous and active-low.
REQ-008 SHALL have superbank ports: sb_req_i in 1; sb_gnt_o out 1; sb_add_i in TCDMAddrWidth; sb_amo_i in AmoWidth; sb_wen_i in 1 (1 store); sb_wdata_i in DMADataWidth; sb_be_i in DMADataWidth/8; sb_rdata_o out DMADataWidth.
REQ-009 SHALL have bank ports, [B] arrays: bank_req_o out 1; bank_gnt_i in 1; bank_add_o out TCDMAddrWidth; bank_amo_o out AmoWidth; bank_wen_o out 1; bank_wdata_o out BW; bank_be_o out BW/8; bank_rdata_i in BW.

Function
REQ-010 SHALL map slice i: bank_wdata_o[i] = sb_wdata_i[i*BW +: BW], bank_be_o[i] = sb_be_i[i*BW/8 +: BW/8]; add/amo/wen broadcast to all banks.
REQ-011 SHALL define needed[i] = 1 for loads; for stores needed[i] = |be slice i (all-zero slices never requested, count as satisfied).
REQ-012 SHALL keep done_mask[B], reset 0; bank_req_o[i] = sb_req_i & needed[i] & ~done_mask[i].
REQ-013 SHALL run FSM IDLE/PARTIAL, reset IDLE; IDLE means done_mask = 0.
REQ-014 SHALL assert sb_gnt_o combinationally when sb_req_i and (done_mask | (bank_req_o & bank_gnt_i) | ~needed) is all-ones.
REQ-015 On sb_gnt_o: done_mask <= 0, state <= IDLE (same cycle completion allowed from IDLE, zero added latency).
REQ-016 On sb_req_i without sb_gnt_o: done_mask <= done_mask | (bank_req_o & bank_gnt_i), state <= PARTIAL when any new grant.
REQ-017 Initiator SHALL hold sb_req_i and all sb_* inputs stable until sb_gnt_o; responder does not check.
REQ-018 A store slice granted early SHALL be committed once; never re-requested within the transaction.
REQ-019 SHALL delay each bank's load grant pulse by L cycles (per-bank shift register, reset 0); on delayed pulse, capture bank_rdata_i[i] into hold buffer slice i.
REQ-020 SHALL delay per-bank "granted before final cycle" flag by L cycles relative to sb_gnt_o; sb_rdata_o slice i = hold buffer if flag set, else live bank_rdata_i[i].
REQ-021 sb_rdata_o SHALL be valid exactly L cycles after sb_gnt_o for loads; undefined-but-stable contents otherwise.
REQ-022 Back-to-back transactions (new request cycle after sb_gnt_o) SHALL be supported at full throughput without buffer corruption.
REQ-023 sb_req_i deasserted while PARTIAL is a protocol violation; responder SHALL hold done_mask and issue no bank requests.
REQ-024 Implementation SHALL be 120-400 lines, no combinational loop from bank_gnt_i to bank_req_o.

Reset
REQ-025 rst_ni low SHALL asynchronously clear done_mask, FSM to IDLE, all delay pipes and hold buffer to 0.
REQ-026 During reset sb_gnt_o, bank_req_o SHALL follow REQ-012/014 from reset state; sb_rdata_o reads 0 from cleared selection flags and live data.
REQ-027 Reset mid-PARTIAL SHALL abandon transaction; next request restarts all needed slices.

Verification (B=8, BW=64, L=1)
REQ-028 Load, all 8 gnt high in cycle 0 -> sb_gnt_o cycle 0, sb_rdata_o = concatenated live rdata cycle 1.
REQ-029 Load, banks 0-3 gnt cycle 0, banks 4-7 cycle 2 -> bank_req_o = 0xF0 cycles 1-2, sb_gnt_o cycle 2, rdata cycle 3 slices 0-3 from buffer (cycle-1 values), 4-7 live.
REQ-030 Store, sb_be_i = 0x00FF_0000_0000_0000 -> only bank_req_o[6] asserted; gnt cycle 0 -> sb_gnt_o cycle 0.
REQ-031 Two back-to-back loads, second with bank 5 stalled 3 cycles -> first rdata correct cycle 1, second rdata correct 1 cycle after its gnt.
REQ-032 rst_ni pulsed low in PARTIAL with done_mask 0x0F -> done_mask 0 immediately, next load requests 0xFF.

Source files
------------

// File: rtl/superbank_responder.sv
// rtl/superbank_responder.sv - fans one wide superbank access out to B narrow banks and reassembles read data
module superbank_responder #(
  parameter int TCDMAddrWidth     = 10,
  parameter int BanksPerSuperbank = 8,
  parameter int DMADataWidth      = 512,
  parameter int AmoWidth          = 4,
  parameter int MemoryLatency     = 1,
  localparam int BankDataWidth    = DMADataWidth / BanksPerSuperbank,
  localparam int BankBeWidth      = BankDataWidth / 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         sb_req_i,
  output logic                         sb_gnt_o,
  input  logic [TCDMAddrWidth-1:0]     sb_add_i,
  input  logic [AmoWidth-1:0]          sb_amo_i,
  input  logic                         sb_wen_i,
  input  logic [DMADataWidth-1:0]      sb_wdata_i,
  input  logic [DMADataWidth/8-1:0]    sb_be_i,
  output logic [DMADataWidth-1:0]      sb_rdata_o,
  output logic [BanksPerSuperbank-1:0] bank_req_o,
  input  logic [BanksPerSuperbank-1:0] bank_gnt_i,
  output logic [TCDMAddrWidth-1:0]     bank_add_o   [BanksPerSuperbank],
  output logic [AmoWidth-1:0]          bank_amo_o   [BanksPerSuperbank],
  output logic [BanksPerSuperbank-1:0] bank_wen_o,
  output logic [BankDataWidth-1:0]     bank_wdata_o [BanksPerSuperbank],
  output logic [BankBeWidth-1:0]       bank_be_o    [BanksPerSuperbank],
  input  logic [BankDataWidth-1:0]     bank_rdata_i [BanksPerSuperbank]
);

  localparam int NB = BanksPerSuperbank;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PARTIAL = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [NB-1:0]      done_q, done_d;
  logic [NB-1:0]      needed;
  logic [NB-1:0]      granted;

  // Load-grant pulses and "serviced before the final cycle" flags, each delayed by the bank latency
  logic [NB-1:0]      ld_pulse_d;
  logic [NB-1:0]      early_sel_d;
  logic [NB-1:0]      ld_pipe_q  [MemoryLatency];
  logic [NB-1:0]      sel_pipe_q [MemoryLatency];
  logic [NB-1:0]      ld_tap;
  logic [NB-1:0]      sel_tap;

  logic [BankDataWidth-1:0] hold_q [NB];
  logic [BankDataWidth-1:0] hold_d [NB];

  // Slice the wide request per bank; all-zero store slices are not needed at all
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      bank_add_o[i]   = sb_add_i;
      bank_amo_o[i]   = sb_amo_i;
      bank_wen_o[i]   = sb_wen_i;
      bank_wdata_o[i] = sb_wdata_i[i*BankDataWidth +: BankDataWidth];
      bank_be_o[i]    = sb_be_i[i*BankBeWidth +: BankBeWidth];
      needed[i]       = sb_wen_i ? (|sb_be_i[i*BankBeWidth +: BankBeWidth]) : 1'b1;
    end
  end

  // Request only slices still outstanding; bank grants never feed back into the requests
  always_comb begin
    bank_req_o = {NB{sb_req_i}} & needed & ~done_q;
    granted    = bank_req_o & bank_gnt_i;
    sb_gnt_o   = sb_req_i & (&(done_q | granted | ~needed));
  end

  // Accumulate per-bank completion until every needed slice has been serviced
  always_comb begin
    done_d  = done_q;
    state_d = state_q;
    if (sb_gnt_o) begin
      done_d  = '0;
      state_d = IDLE;
    end else if (sb_req_i) begin
      done_d = done_q | granted;
      if (|granted) begin
        state_d = PARTIAL;
      end
    end
  end

  // Transaction state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Early-serviced slices read from the hold buffer when the whole access completes
  always_comb begin
    ld_pulse_d  = granted & {NB{~sb_wen_i}};
    early_sel_d = (sb_gnt_o && !sb_wen_i) ? done_q : '0;
    ld_tap      = ld_pipe_q[MemoryLatency-1];
    sel_tap     = sel_pipe_q[MemoryLatency-1];
  end

  // Latency-matching shift registers for grant pulses and output selection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < MemoryLatency; k++) begin
        ld_pipe_q[k]  <= '0;
        sel_pipe_q[k] <= '0;
      end
    end else begin
      ld_pipe_q[0]  <= ld_pulse_d;
      sel_pipe_q[0] <= early_sel_d;
      for (int k = 1; k < MemoryLatency; k++) begin
        ld_pipe_q[k]  <= ld_pipe_q[k-1];
        sel_pipe_q[k] <= sel_pipe_q[k-1];
      end
    end
  end

  // Capture a bank's read data in the cycle it arrives for that bank's grant
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      hold_d[i] = ld_tap[i] ? bank_rdata_i[i] : hold_q[i];
    end
  end

  // Hold buffer storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NB; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  // Reassemble the wide read word from buffered and live slices
  always_comb begin
    sb_rdata_o = '0;
    for (int i = 0; i < NB; i++) begin
      sb_rdata_o[i*BankDataWidth +: BankDataWidth] = sel_tap[i] ? hold_q[i] : bank_rdata_i[i];
    end
  end

endmodule

// File: tb/tb_superbank_responder.sv
// tb/tb_superbank_responder.sv - randomized scoreboard bench for superbank_responder
module tb_superbank_responder;

  localparam int B    = 8;
  localparam int BW   = 64;
  localparam int DW   = 512;
  localparam int AW   = 10;
  localparam int AMOW = 4;
  localparam int L    = 1;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            sb_req_i, sb_gnt_o, sb_wen_i;
  logic [AW-1:0]   sb_add_i;
  logic [AMOW-1:0] sb_amo_i;
  logic [DW-1:0]   sb_wdata_i, sb_rdata_o;
  logic [DW/8-1:0] sb_be_i;
  logic [B-1:0]    bank_req_o, bank_gnt_i, bank_wen_o;
  logic [AW-1:0]   bank_add_o   [B];
  logic [AMOW-1:0] bank_amo_o   [B];
  logic [BW-1:0]   bank_wdata_o [B];
  logic [BW/8-1:0] bank_be_o    [B];
  logic [BW-1:0]   bank_rdata_i [B];

  superbank_responder #(
    .TCDMAddrWidth(AW), .BanksPerSuperbank(B), .DMADataWidth(DW),
    .AmoWidth(AMOW), .MemoryLatency(L)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .sb_req_i(sb_req_i), .sb_gnt_o(sb_gnt_o), .sb_add_i(sb_add_i), .sb_amo_i(sb_amo_i),
    .sb_wen_i(sb_wen_i), .sb_wdata_i(sb_wdata_i), .sb_be_i(sb_be_i), .sb_rdata_o(sb_rdata_o),
    .bank_req_o(bank_req_o), .bank_gnt_i(bank_gnt_i), .bank_add_o(bank_add_o),
    .bank_amo_o(bank_amo_o), .bank_wen_o(bank_wen_o), .bank_wdata_o(bank_wdata_o),
    .bank_be_o(bank_be_o), .bank_rdata_i(bank_rdata_i)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the current transaction and which banks have serviced it
  bit              act;
  bit              t_wen;
  logic [DW/8-1:0] t_be;
  logic [DW-1:0]   t_wdata;
  logic [AW-1:0]   t_add;
  logic [AMOW-1:0] t_amo;
  logic [B-1:0]    got;
  int              gcyc   [B];
  int              gcount [B];
  int              cyc;
  logic [DW-1:0]   rd_hist [MAXC];
  int              due_q [$];
  logic [B*16-1:0] gc_q  [$];

  task automatic start_tx(input bit wen, input logic [DW/8-1:0] be);
    act     = 1'b1;
    t_wen   = wen;
    t_be    = be;
    t_wdata = {16{$urandom()}};
    for (int i = 0; i < B; i++) t_wdata[i*BW +: 32] = $urandom();
    t_add   = AW'($urandom());
    t_amo   = AMOW'($urandom());
    got     = '0;
    for (int i = 0; i < B; i++) begin
      gcyc[i]   = 0;
      gcount[i] = 0;
    end
  endtask

  task automatic start_rand();
    logic [DW/8-1:0] be;
    be = '0;
    for (int i = 0; i < B; i++) begin
      case ($urandom_range(0, 3))
        0:       be[i*8 +: 8] = 8'h00;
        1:       be[i*8 +: 8] = 8'hFF;
        default: be[i*8 +: 8] = 8'($urandom());
      endcase
    end
    start_tx(1'($urandom_range(0, 1)), be);
  endtask

  // One clock cycle: drive at posedge+1, check at posedge+3, advance the model
  task automatic cycle(input logic [B-1:0] gnt_pat);
    logic [B-1:0]    need, exp_req;
    bit              exp_gnt;
    logic [DW-1:0]   live, exp_rd, flat_wd;
    logic [DW/8-1:0] flat_be;
    logic [B*15-1:0] flat_ctl, exp_ctl;
    logic [B*16-1:0] gc;
    int              d;
    sb_req_i   = act;
    sb_wen_i   = t_wen;
    sb_be_i    = t_be;
    sb_wdata_i = t_wdata;
    sb_add_i   = t_add;
    sb_amo_i   = t_amo;
    bank_gnt_i = gnt_pat;
    for (int i = 0; i < B; i++) bank_rdata_i[i] = {$urandom(), $urandom()};
    #2;
    for (int i = 0; i < B; i++) live[i*BW +: BW] = bank_rdata_i[i];
    if (cyc < MAXC) rd_hist[cyc] = live;

    for (int i = 0; i < B; i++) need[i] = t_wen ? (t_be[i*8 +: 8] != 8'h00) : 1'b1;
    exp_req = act ? (need & ~got) : '0;
    exp_gnt = act && ((got | (exp_req & gnt_pat) | ~need) == {B{1'b1}});
    check("bank_req", bank_req_o, exp_req);
    check("sb_gnt", sb_gnt_o, exp_gnt);

    while (due_q.size() > 0 && due_q[0] == cyc) begin
      gc = gc_q[0];
      for (int i = 0; i < B; i++) begin
        d = int'(gc[i*16 +: 16]) + L;
        exp_rd[i*BW +: BW] = rd_hist[d][i*BW +: BW];
      end
      check("sb_rdata", sb_rdata_o, exp_rd);
      void'(due_q.pop_front());
      void'(gc_q.pop_front());
    end

    if (act && exp_req != '0) begin
      for (int i = 0; i < B; i++) begin
        flat_wd[i*BW +: BW]  = bank_wdata_o[i];
        flat_be[i*8 +: 8]    = bank_be_o[i];
        flat_ctl[i*15 +: 15] = {bank_add_o[i], bank_amo_o[i], bank_wen_o[i]};
        exp_ctl[i*15 +: 15]  = {t_add, t_amo, t_wen};
      end
      check("bank_wdata", flat_wd, t_wdata);
      check("bank_be", flat_be, t_be);
      check("bank_ctl", flat_ctl, exp_ctl);
    end

    for (int i = 0; i < B; i++) begin
      if (exp_req[i] && gnt_pat[i]) begin
        got[i]  = 1'b1;
        gcyc[i] = cyc;
        gcount[i]++;
      end
    end
    if (exp_gnt) begin
      if (t_wen) begin
        for (int i = 0; i < B; i++) check("store_once", gcount[i], need[i] ? 1 : 0);
      end else begin
        for (int i = 0; i < B; i++) gc[i*16 +: 16] = 16'(gcyc[i]);
        due_q.push_back(cyc + L);
        gc_q.push_back(gc);
      end
      act = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    act = 1'b0; t_wen = 1'b0; t_be = '0; t_wdata = '0; t_add = '0; t_amo = '0; got = '0;
    cyc = 0;
    sb_req_i = 1'b0; sb_wen_i = 1'b0; sb_be_i = '0; sb_wdata_i = '0; sb_add_i = '0; sb_amo_i = '0;
    bank_gnt_i = '0;
    for (int i = 0; i < B; i++) bank_rdata_i[i] = '0;
    rst_n = 1'b0;
    #3;
    check("reset_gnt", sb_gnt_o, 1'b0);
    check("reset_req", bank_req_o, 8'h00);
    check("reset_rdata", sb_rdata_o, '0);
    sb_req_i = 1'b1;
    #1;
    check("reset_req_live", bank_req_o, 8'hFF);
    bank_gnt_i = 8'hFF;
    #1;
    check("reset_gnt_live", sb_gnt_o, 1'b1);
    sb_req_i = 1'b0; bank_gnt_i = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic with frequent back-to-back transactions
    for (int n = 0; n < 1500; n++) begin
      if (!act && $urandom_range(0, 4) != 0) start_rand();
      if ($urandom_range(0, 3) == 0) cycle(8'hFF);
      else cycle(8'($urandom()));
    end
    for (int n = 0; n < 4; n++) cycle(8'hFF);

    // Split load: banks 0-3 early, 4-7 two cycles later
    start_tx(1'b0, '0);
    cycle(8'h0F);
    cycle(8'h00);
    cycle(8'hF0);
    cycle(8'h00);
    // Store touching only bank 6
    start_tx(1'b1, 64'h00FF_0000_0000_0000);
    cycle(8'hFF);
    // Two back-to-back loads, bank 5 stalled on the second
    start_tx(1'b0, '0);
    cycle(8'hFF);
    start_tx(1'b0, '0);
    cycle(8'hDF);
    cycle(8'h00);
    cycle(8'h00);
    cycle(8'h20);
    cycle(8'h00);
    cycle(8'h00);
    check("rd_pending", due_q.size(), 0);

    // Reset abandons a half-serviced load
    start_tx(1'b0, '0);
    cycle(8'h0F);
    sb_req_i = 1'b1; sb_wen_i = 1'b0; bank_gnt_i = 8'h00;
    #1;
    check("partial_req", bank_req_o, 8'hF0);
    rst_n = 1'b0;
    #1;
    check("mid_reset_req", bank_req_o, 8'hFF);
    check("mid_reset_gnt", sb_gnt_o, 1'b0);
    got = '0;
    for (int i = 0; i < B; i++) gcount[i] = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
    cycle(8'hFF);
    cycle(8'h00);
    check("rd_pending_end", due_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
